button_debouncer: RTL and testbench

//  Front-end conditioning for the calculator's push-buttons. Each raw button is

---
 rtl/calc_pkg.sv | 29 ++
 rtl/debounce_channel.sv | 81 ++++++++
 rtl/button_debouncer.sv | 39 +++
 tb/tb_button_debouncer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: button map, default sizes and helper functions
// used by the push-button front end and the downstream calculator stages.
package calc_pkg;

  // 10 ms of stable input at a 100 MHz system clock
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  // Five buttons on the board: centre, up, down, left, right
  localparam int DEFAULT_NUM_BTN = 5;

  // Button bit positions within the btn_* vectors
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;

  // Width of a stability counter that counts 0 .. cycles-1.
  // It never drops below one bit, so a degenerate setting still elaborates.
  function automatic int cntWidth(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: a two-flop synchroniser, a stability counter and the
// registered level / press / release outputs.
module debounce_channel
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int CNT_W = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;

  logic [CNT_W-1:0] w_cntNext;
  logic             w_levelNext;
  logic             w_pressNext;
  logic             w_releaseNext;

  // Bring the asynchronous pin into the clock domain; only r_sync2 is used past here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count how long the synchronised input has disagreed with the committed level.
  // Any agreement restarts the count. The level commits after the count reaches its maximum.
  always_comb begin
    w_cntNext     = r_cnt;
    w_levelNext   = r_level;
    w_pressNext   = 1'b0;
    w_releaseNext = 1'b0;
    if (r_sync2 == r_level) begin
      w_cntNext = '0;
    end else if (r_cnt == CNT_MAX) begin
      w_cntNext     = '0;
      w_levelNext   = r_sync2;
      w_pressNext   = r_sync2;
      w_releaseNext = ~r_sync2;
    end else begin
      w_cntNext = r_cnt + CNT_ONE;
    end
  end

  // Hold the counter, the committed level and the single-cycle edge pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_cnt     <= w_cntNext;
      r_level   <= w_levelNext;
      r_press   <= w_pressNext;
      r_release <= w_releaseNext;
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule

// File: rtl/button_debouncer.sv
// Push-button front end: one independent debounce channel per board button.
// Downstream stages use btn_level or btn_press instead of the raw pins.
module button_debouncer
  import calc_pkg::*;
#(
  parameter int NUM_BTN         = DEFAULT_NUM_BTN,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_release;

  // The channels share no state, so simultaneous presses produce pulses in the same cycle
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_channel
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_channel (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw[i]),
      .btn_level  (w_level[i]),
      .btn_press  (w_press[i]),
      .btn_release(w_release[i])
    );
  end

  assign btn_level   = w_level;
  assign btn_press   = w_press;
  assign btn_release = w_release;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with a short debounce window.
module tb_button_debouncer;

  localparam int NB  = 5;
  localparam int DC  = 4;
  localparam int LAT = DC + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  int errCount   = 0;
  int checkCount = 0;
  int cyc        = 0;

  typedef struct {
    int            cyc;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] lvl;
  } evt_t;

  evt_t          expQ[$];
  evt_t          monEvt;
  logic [NB-1:0] expLevel = '0;

  button_debouncer #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Edge counter, so an expected pulse can be tied to a specific edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Drive the raw pins. When a commit is expected, queue it for edge 2+DC counted from the next edge.
  task automatic applyStimulus(input logic [NB-1:0] raw, input bit expectEvt,
                               input logic [NB-1:0] press, input logic [NB-1:0] rel,
                               input logic [NB-1:0] lvl);
    evt_t e;
    btn_raw = raw;
    if (expectEvt) begin
      e.cyc   = cyc + LAT;
      e.press = press;
      e.rel   = rel;
      e.lvl   = lvl;
      expQ.push_back(e);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse must match the next queued event, and the level must follow the events
  always @(negedge clk) begin
    if (rst) begin
      expLevel = '0;
      checkOutput("resetLevel", 32'(btn_level), 32'(0));
      checkOutput("resetPress", 32'(btn_press), 32'(0));
      checkOutput("resetRelease", 32'(btn_release), 32'(0));
    end else begin
      checkOutput("exclusive", 32'(btn_press & btn_release), 32'(0));
      if (|(btn_press | btn_release)) begin
        if (expQ.size() == 0) begin
          checkCount++;
          errCount++;
          $display("[TB] FAIL unexpectedPulse: got press=%b release=%b required none at cycle %0d",
                   btn_press, btn_release, cyc);
        end else begin
          monEvt = expQ.pop_front();
          checkOutput("pulseCycle", 32'(cyc), 32'(monEvt.cyc));
          checkOutput("press", 32'(btn_press), 32'(monEvt.press));
          checkOutput("release", 32'(btn_release), 32'(monEvt.rel));
          expLevel = monEvt.lvl;
        end
      end
      checkOutput("level", 32'(btn_level), 32'(expLevel));
    end
  end

  // Bound the run length
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus
  initial begin
    // Reset with every button held down
    rst     = 1'b1;
    btn_raw = 5'b11111;
    waitCycles(3);
    rst = 1'b0;
    applyStimulus(5'b11111, 1'b1, 5'b11111, 5'b00000, 5'b11111);
    waitCycles(LAT + 3);
    applyStimulus(5'b00000, 1'b1, 5'b00000, 5'b11111, 5'b00000);
    waitCycles(LAT + 3);

    // Clean press and release on the centre button
    $display("[TB] clean press");
    applyStimulus(5'b00001, 1'b1, 5'b00001, 5'b00000, 5'b00001);
    waitCycles(20);
    applyStimulus(5'b00000, 1'b1, 5'b00000, 5'b00001, 5'b00000);
    waitCycles(LAT + 3);

    // Bounce bursts shorter than the window, then a held press
    $display("[TB] bounce");
    applyStimulus(5'b00100, 1'b0, '0, '0, '0);
    waitCycles(3);
    applyStimulus(5'b00000, 1'b0, '0, '0, '0);
    waitCycles(2);
    applyStimulus(5'b00100, 1'b0, '0, '0, '0);
    waitCycles(3);
    applyStimulus(5'b00000, 1'b0, '0, '0, '0);
    waitCycles(2);
    applyStimulus(5'b00100, 1'b1, 5'b00100, 5'b00000, 5'b00100);
    waitCycles(LAT + 3);
    applyStimulus(5'b00000, 1'b1, 5'b00000, 5'b00100, 5'b00000);
    waitCycles(LAT + 3);

    // Single-cycle glitch on the right button
    $display("[TB] glitch");
    applyStimulus(5'b10000, 1'b0, '0, '0, '0);
    waitCycles(1);
    applyStimulus(5'b00000, 1'b0, '0, '0, '0);
    repeat (20) begin
      @(negedge clk);
      checkOutput("glitchLevel", 32'(btn_level[4]), 32'(0));
      checkOutput("glitchPress", 32'(btn_press[4]), 32'(0));
      checkOutput("glitchRelease", 32'(btn_release[4]), 32'(0));
    end
    waitCycles(1);

    // Up and left pressed together
    $display("[TB] simultaneous");
    applyStimulus(5'b01010, 1'b1, 5'b01010, 5'b00000, 5'b01010);
    waitCycles(LAT + 3);
    applyStimulus(5'b00000, 1'b1, 5'b00000, 5'b01010, 5'b00000);
    waitCycles(LAT + 3);

    // Reset part-way through a count, then the full latency again
    $display("[TB] reset mid-count");
    applyStimulus(5'b00001, 1'b0, '0, '0, '0);
    waitCycles(3);
    rst = 1'b1;
    waitCycles(2);
    rst = 1'b0;
    applyStimulus(5'b00001, 1'b1, 5'b00001, 5'b00000, 5'b00001);
    waitCycles(LAT + 3);
    applyStimulus(5'b00000, 1'b1, 5'b00000, 5'b00001, 5'b00000);
    waitCycles(LAT + 3);

    checkOutput("queueEmpty", 32'(expQ.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
